// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed 32x32 Booth multiply / restoring divide; DIVZERO_EXC_EN makes divide-by-zero finish at once with div_zero.
module mult_div_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic        mult_start,
    input  logic        div_start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);
    typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;
    state_t state, state_n;
    logic [4:0]  cnt;
    logic [32:0] acc;
    logic [31:0] q, m, mag_a, mag_b;
    logic        q1, neg_q, neg_r, is_div, dz_exc, div_ge;
    logic [32:0] booth_sum, div_shift;
    assign busy  = state != IDLE;
    assign mag_a = a[31] ? -a : a;
    assign mag_b = b[31] ? -b : b;
`ifdef DIVZERO_EXC_EN
    assign dz_exc = b == 32'd0;
`else
    assign dz_exc = 1'b0;
`endif
    // acc/q double as Booth {partial, multiplier} and divide {remainder, quotient}
    assign booth_sum = (q[0] && !q1) ? acc - {m[31], m} : (!q[0] && q1) ? acc + {m[31], m} : acc;
    assign div_shift = {acc[31:0], q[31]};
    assign div_ge    = div_shift >= {1'b0, m};
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     state_n = div_start ? (dz_exc ? DONE : DIV) : mult_start ? MULT : IDLE;
            MULT,
            DIV:      state_n = cnt == 5'd31 ? FIX : state;
            FIX:      state_n = DONE;
            default:  state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            q        <= '0;
            m        <= '0;
            q1       <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            is_div   <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= (state == MULT || state == DIV) ? cnt + 5'd1 : 5'd0;
            case (state)
                IDLE: begin
                    if (div_start) begin
                        acc      <= '0;
                        q        <= mag_a;
                        m        <= mag_b;
                        neg_q    <= a[31] ^ b[31];
                        neg_r    <= a[31];
                        is_div   <= 1'b1;
                        done     <= dz_exc;
                        div_zero <= dz_exc;
                    end else if (mult_start) begin
                        acc    <= '0;
                        q      <= b;
                        m      <= a;
                        q1     <= 1'b0;
                        is_div <= 1'b0;
                    end
                end
                MULT: {acc, q, q1} <= {booth_sum[32], booth_sum, q};
                DIV: begin
                    acc <= div_ge ? div_shift - {1'b0, m} : div_shift;
                    q   <= {q[30:0], div_ge};
                end
                FIX: begin
                    lo   <= (is_div && neg_q) ? -q : q;
                    hi   <= (is_div && neg_r) ? -acc[31:0] : acc[31:0];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of multiply, divide, priority, div-by-zero and reset abort.
module tb_mult_div_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mult_start = 1'b0;
    logic        div_start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;
    int          errors = 0;
    int          checks = 0;

    mult_div_unit dut (
        .clock(clock), .reset(reset), .mult_start(mult_start), .div_start(div_start),
        .a(a), .b(b), .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_op(input logic ms, input logic ds, input logic [31:0] av, input logic [31:0] bv);
        mult_start = ms;
        div_start  = ds;
        a = av;
        b = bv;
        tick();
        mult_start = 1'b0;
        div_start  = 1'b0;
        a = 32'hDEAD_BEEF;
        b = 32'h0BAD_F00D;
    endtask

    task automatic run_to_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 40);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({hi, lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
        checks++;
        if ({busy, done, div_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {busy, done, div_zero}); end
        reset = 1'b0;
    endtask

    task automatic test_op(input string nm, input logic ds, input logic [31:0] av, input logic [31:0] bv, input logic [63:0] exp_hilo);
        int n;
        start_op(!ds, ds, av, bv);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_e0 got %b want 1", nm, busy); end
        run_to_done(n);
        checks++;
        if (n !== 33) begin errors++; $display("FAIL %s latency got %0d want 33", nm, n); end
        checks++;
        if ({hi, lo} !== exp_hilo) begin errors++; $display("FAIL %s hilo got %h want %h", nm, {hi, lo}, exp_hilo); end
        checks++;
        if (div_zero !== 1'b0) begin errors++; $display("FAIL %s div_zero got %b want 0", nm, div_zero); end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin errors++; $display("FAIL %s e34_busy_done got %b want 00", nm, {busy, done}); end
    endtask

    task automatic test_mult();
        test_op("mul_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        test_op("mul_min2", 1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        test_op("mul_pos", 1'b0, 32'd12345, 32'd6789, 64'h0000_0000_04FE_D79D);
        test_op("mul_neg2", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
    endtask

    task automatic test_div();
        test_op("div_-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        test_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        test_op("div_7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD);
        test_op("div_-100/-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 64'hFFFF_FFFE_0000_000E);
    endtask

    task automatic test_div_zero();
`ifdef DIVZERO_EXC_EN
        start_op(1'b0, 1'b1, 32'h1234_5678, 32'd0);
        checks++;
        if ({done, div_zero, busy} !== 3'b111) begin errors++; $display("FAIL dz_e0_flags got %b want 111", {done, div_zero, busy}); end
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFE_0000_000E) begin errors++; $display("FAIL dz_hilo_kept got %h want fffffffe0000000e", {hi, lo}); end
        tick();
        checks++;
        if ({done, div_zero, busy} !== 3'b000) begin errors++; $display("FAIL dz_e1_flags got %b want 000", {done, div_zero, busy}); end
`else
        test_op("div_zero", 1'b1, 32'h1234_5678, 32'd0, 64'h1234_5678_FFFF_FFFF);
`endif
    endtask

    task automatic test_priority();
        int n;
        int extra;
        start_op(1'b1, 1'b1, 32'd100, 32'd7);
        repeat (4) tick();
        mult_start = 1'b1;
        a = 32'd3;
        b = 32'd3;
        tick();
        mult_start = 1'b0;
        run_to_done(n);
        n += 5;
        checks++;
        if (n !== 33) begin errors++; $display("FAIL prio_latency got %0d want 33", n); end
        checks++;
        if ({hi, lo} !== {32'd2, 32'd14}) begin errors++; $display("FAIL prio_hilo got %h want 000000020000000e", {hi, lo}); end
        extra = 0;
        repeat (40) begin
            tick();
            if (done) extra++;
        end
        checks++;
        if (extra !== 0) begin errors++; $display("FAIL prio_second_done got %0d want 0", extra); end
    endtask

    task automatic test_reset_abort();
        int n;
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({busy, done, hi, lo} !== 66'd0) begin errors++; $display("FAIL abort_state got %h want 0", {busy, done, hi, lo}); end
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        run_to_done(n);
        checks++;
        if (n !== 33) begin errors++; $display("FAIL abort_restart_latency got %0d want 33", n); end
        checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL abort_restart_hilo got %h want ffffffffffffffeb", {hi, lo}); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_priority();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have clock, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have reset, input, 1, synchronous active-high reset, sampled on the clock rising edge.
REQ-003 SHALL have mult_start, input, 1, start a signed multiply when sampled high in IDLE.
REQ-004 SHALL have div_start, input, 1, start a signed divide when sampled high in IDLE.
REQ-005 SHALL have a, input, 32, operand A: multiplicand or dividend, two's complement.
REQ-006 SHALL have b, input, 32, operand B: multiplier or divisor, two's complement.
REQ-007 SHALL have hi, output, 32, registered: product[63:32], or the remainder.
REQ-008 SHALL have lo, output, 32, registered: product[31:0], or the quotient.
REQ-009 SHALL have busy, output, 1, high whenever state is not IDLE.
REQ-010 SHALL have done, output, 1, registered single-cycle pulse marking hi/lo valid.
REQ-011 SHALL have div_zero, output, 1, registered; high together with done when a divide had b==0.

Function
REQ-012 SHALL implement states IDLE, MULT, DIV, FIX, DONE.
REQ-013 IDLE: a and b SHALL be captured on the edge that samples a start; the operation is then accepted.
REQ-014 SHALL give div_start priority when both starts are high on the same edge; the multiply is dropped.
REQ-015 SHALL ignore starts sampled in any state other than IDLE; no queuing.
REQ-016 MULT SHALL run radix-2 Booth over 32 edges, counter 0..31; the last edge SHALL move to FIX.
REQ-017 DIV SHALL run restoring division on operand magnitudes over 32 edges; the last edge SHALL move to FIX.
REQ-018 FIX SHALL apply signs on one edge and load hi/lo. Quotient sign = sign(a) XOR sign(b). Remainder sign = sign(a). Then: done=1, state DONE.
REQ-019 DONE SHALL clear done and div_zero on the next edge and return to IDLE.
REQ-020 Latency: start sampled at edge E0 -> hi/lo loaded and done=1 at edge E33; done=0 and IDLE at E34; next start is accepted at E34 at the earliest.
REQ-021 Multiply SHALL produce the exact signed 64-bit product; 0x80000000*0x80000000 = 0x40000000_00000000.
REQ-022 Divide overflow: 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, wrapped, no flag.
REQ-023 hi/lo SHALL hold their last values except at FIX, at reset, or per REQ-027.
REQ-024 a and b changing after E0 SHALL NOT affect the running operation.

Reset
REQ-025 Reset SHALL force: state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, div_zero=0.
REQ-026 Reset SHALL win over any start on the same edge and SHALL abort an operation in progress with no done pulse.

Configuration
REQ-027 Macro DIVZERO_EXC_EN defined: a divide with b==0 SHALL go IDLE->DONE on E0. It SHALL set done=1 and div_zero=1 at E0 and leave hi/lo unchanged.
REQ-028 DIVZERO_EXC_EN undefined: b==0 SHALL run the normal 32-edge divide. This gives lo = 0xFFFFFFFF XOR'd with the sign per REQ-018 (b treated as positive). It gives hi = a. div_zero SHALL be tied 0.

Verification
REQ-029 mult_start, a=7, b=0xFFFFFFFD (-3) -> at E33: hi=0xFFFFFFFF, lo=0xFFFFFFEB, done=1 for exactly one cycle, busy low at E34.
REQ-030 div_start, a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1), done at E33.
REQ-031 div_start, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
REQ-032 div_start, a=0x12345678, b=0 -> with macro: done=div_zero=1 at E0, hi/lo unchanged. Without macro: lo=0xFFFFFFFF, hi=0x12345678 at E33, div_zero=0.
REQ-033 mult_start and div_start both high with a=100, b=7 -> divide result lo=14, hi=2. A mult_start pulsed at E5 is ignored, and no second done follows.
REQ-034 reset asserted at E10 of a multiply -> at that edge busy=0, hi=lo=0, and no done follows. A new start at E11 completes normally at E44.
